// File: rtl/wbuf_port_sched_pkg.sv
// Shared widths, size encodings and scheduler state for the store write buffer.
package wbuf_port_sched_pkg;

  localparam int unsigned PA_W   = 15;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_3B = 2'b10,
    SZ_4B = 2'b11
  } size_e;

  typedef enum logic {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } state_e;

endpackage

// File: rtl/wbuf_port_sched_overlap_cmp.sv
// Word-range intersect test between one buffered store and the incoming load.
module wbuf_overlap_cmp
  import wbuf_port_sched_pkg::*;
(
  input  logic            en,
  input  logic [PA_W-1:0] st_addr,
  input  logic [1:0]      st_size,
  input  logic [PA_W-1:0] ld_addr,
  input  logic [1:0]      ld_size,
  output logic            hit
);

  logic [PA_W-1:0] st_end;
  logic [PA_W-1:0] ld_end;

  // Ranges are inclusive word indices: first byte's word through last byte's word.
  always_comb begin
    st_end = st_addr + PA_W'(st_size);
    ld_end = ld_addr + PA_W'(ld_size);
    hit    = en
           & (st_addr[PA_W-1:2] <= ld_end[PA_W-1:2])
           & (ld_addr[PA_W-1:2] <= st_end[PA_W-1:2]);
  end

endmodule

// File: rtl/wbuf_port_sched.sv
// Store write buffer FIFO and single D-cache port arbiter between head drain and loads.
module wbuf_port_sched
  import wbuf_port_sched_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_v,
  input  logic [PA_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [1:0]               wb_size,
  output logic                     wb_full,
  input  logic                     rd_req,
  input  logic [PA_W-1:0]          rd_addr,
  input  logic [1:0]               rd_size,
  output logic                     rd_gnt,
  output logic                     rd_block,
  output logic                     dc_op_v,
  output logic                     dc_op_wr,
  output logic [PA_W-1:0]          dc_addr,
  output logic [DATA_W-1:0]        dc_data,
  output logic [1:0]               dc_size,
  input  logic                     dc_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [PA_W-1:0]   addr_q [DEPTH];
  logic [PA_W-1:0]   addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic [1:0]        size_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  state_e            state_q, state_d;

  logic [DEPTH-1:0]  hits;
  logic              is_full, op_v, enq, wr_deq;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    wbuf_overlap_cmp u_cmp (
      .en      (vld_q[g]),
      .st_addr (addr_q[g]),
      .st_size (size_q[g]),
      .ld_addr (rd_addr),
      .ld_size (rd_size),
      .hit     (hits[g])
    );
  end

  always_comb begin
    is_full    = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    count      = count_q;
    wb_full    = is_full | (state_q == FLUSH);
    rd_block   = rd_req & (|hits);
    flush_done = (state_q == FLUSH) & empty & !rst;

    op_v     = 1'b0;
    dc_op_wr = 1'b1;
    dc_addr  = addr_q[head_q];
    dc_size  = size_q[head_q];
    dc_data  = data_q[head_q];
    // Forced-write cases own the port even when empty, so no read slips into FLUSH.
    if ((state_q == FLUSH) || is_full || ((starve_q == SW'(STARVE_MAX)) && !empty)) begin
      op_v = !empty;
    end else if (rd_req && !rd_block) begin
      op_v     = 1'b1;
      dc_op_wr = 1'b0;
      dc_addr  = rd_addr;
      dc_size  = rd_size;
    end else begin
      op_v = !empty;
    end
    dc_op_v = op_v & !rst;
    rd_gnt  = dc_op_v & !dc_op_wr & dc_ready;
    wr_deq  = dc_op_v & dc_op_wr & dc_ready;
    enq     = wb_v & !wb_full;
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (wr_deq) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (enq) begin
      addr_d[tail_q] = wb_addr;
      data_d[tail_q] = wb_data;
      size_d[tail_q] = wb_size;
      vld_d[tail_q]  = 1'b1;
      tail_d         = tail_q + 1'b1;
    end
    count_d = count_q + CW'(enq) - CW'(wr_deq);

    starve_d = starve_q;
    if (wr_deq || empty)                            starve_d = '0;
    else if (rd_gnt && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;

    state_d = state_q;
    case (state_q)
      NORMAL: if (flush_req) state_d = FLUSH;
      FLUSH:  if (empty)     state_d = NORMAL;
      default:               state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      state_q  <= NORMAL;
    end else begin
      vld_q    <= vld_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    size_q <= size_d;
  end

endmodule
